bit_pari_receiver: RTL

Receiving end of the three `c/dav_/rfd` count channels produced by the even-bit counter block.
- Accepts one 3-bit count per channel per round; each channel has its own handshake and its own pace.
- Applies backpressure by holding that channel's `rfd` low until the round is forwarded.
- Majority-votes the three counts and flags disagreement.
- Forwards one result word per round on a single `dav_out_/rfd_out` channel to the downstream sink, and keeps a saturating mismatch count.

---
 rtl/bit_pari_pkg.sv | 20 ++
 rtl/hs_rx_channel.sv | 56 +++++
 rtl/bit_pari_receiver.sv | 107 ++++++++++
 3 files changed

// File: rtl/bit_pari_pkg.sv
// Shared types and default widths for the three-channel count receiver.
package bit_pari_pkg;

    localparam int CW_DEF = 3;
    localparam int RW_DEF = 4;
    localparam int EW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        HELD
    } ch_state_t;

    typedef enum logic [1:0] {
        OIDLE,
        ODAV,
        OACK
    } out_state_t;

endpackage

// File: rtl/hs_rx_channel.sv
// One input channel: accepts a single count per round and holds it, with rfd low,
// until the round has been forwarded downstream.
module hs_rx_channel
    import bit_pari_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clock,
    input  logic          reset_,
    input  logic [CW-1:0] c,
    input  logic          dav_,
    output logic          rfd,
    output logic [CW-1:0] r,
    output logic          held,
    input  logic          release_pulse
);

    ch_state_t state;

    assign held = (state == HELD);

    // dav_ activity in ACK/HELD only advances ACK->HELD; no second capture per round
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            rfd   <= 1'b1;
            r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!dav_) begin
                        r     <= c;
                        rfd   <= 1'b0;
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (dav_) begin
                        state <= HELD;
                    end
                end
                HELD: begin
                    if (release_pulse) begin
                        rfd   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    rfd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/bit_pari_receiver.sv
// Collects one count from each of three channels, majority-votes them and forwards
// one result word per round, tracking the round index and a saturating mismatch count.
module bit_pari_receiver
    import bit_pari_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int RW = RW_DEF,
    parameter int EW = EW_DEF
) (
    input  logic          clock,
    input  logic          reset_,
    input  logic [CW-1:0] c1,
    input  logic [CW-1:0] c2,
    input  logic [CW-1:0] c3,
    input  logic          dav1_,
    input  logic          dav2_,
    input  logic          dav3_,
    output logic          rfd1,
    output logic          rfd2,
    output logic          rfd3,
    output logic [CW-1:0] c_out,
    output logic          mismatch,
    output logic [RW-1:0] round,
    output logic          dav_out_,
    input  logic          rfd_out,
    output logic [EW-1:0] err_cnt
);

    logic [CW-1:0] r1, r2, r3;
    logic          held1, held2, held3;
    logic          rel;
    logic [CW-1:0] vote;
    logic          vote_mm;
    out_state_t    ostate;

    hs_rx_channel #(.CW(CW)) u_ch1 (
        .clock(clock), .reset_(reset_), .c(c1), .dav_(dav1_), .rfd(rfd1),
        .r(r1), .held(held1), .release_pulse(rel)
    );

    hs_rx_channel #(.CW(CW)) u_ch2 (
        .clock(clock), .reset_(reset_), .c(c2), .dav_(dav2_), .rfd(rfd2),
        .r(r2), .held(held2), .release_pulse(rel)
    );

    hs_rx_channel #(.CW(CW)) u_ch3 (
        .clock(clock), .reset_(reset_), .c(c3), .dav_(dav3_), .rfd(rfd3),
        .r(r3), .held(held3), .release_pulse(rel)
    );

    // With no pair agreeing, channel 1 is taken as the tie-break
    always_comb begin
        vote    = r1;
        vote_mm = !((r1 == r2) && (r2 == r3));
        if ((r1 == r2) || (r1 == r3)) begin
            vote = r1;
        end else if (r2 == r3) begin
            vote = r2;
        end
    end

    // Channels are still HELD during the release cycle, so rel blocks a phantom restart
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            ostate   <= OIDLE;
            c_out    <= '0;
            mismatch <= 1'b0;
            round    <= '0;
            err_cnt  <= '0;
            dav_out_ <= 1'b1;
            rel      <= 1'b0;
        end else begin
            rel <= 1'b0;
            case (ostate)
                OIDLE: begin
                    if (held1 && held2 && held3 && !rel) begin
                        c_out    <= vote;
                        mismatch <= vote_mm;
                        dav_out_ <= 1'b0;
                        ostate   <= ODAV;
                    end
                end
                ODAV: begin
                    if (!rfd_out) begin
                        dav_out_ <= 1'b1;
                        ostate   <= OACK;
                    end
                end
                OACK: begin
                    if (rfd_out) begin
                        rel    <= 1'b1;
                        round  <= round + 1'b1;
                        if (mismatch && (err_cnt != '1)) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        ostate <= OIDLE;
                    end
                end
                default: begin
                    dav_out_ <= 1'b1;
                    ostate   <= OIDLE;
                end
            endcase
        end
    end

endmodule
